// File: rtl/sync_sample_fifo_pkg.sv
// sync_sample_fifo_pkg: shared defaults and register-map status bit positions for the sample FIFO
package sync_sample_fifo_pkg;
  localparam int DATA_W_DEF     = 32;
  localparam int DEPTH_LOG2_DEF = 3;
  localparam int STAT_EMPTY_BIT = 0;
  localparam int STAT_FULL_BIT  = 1;
  localparam int STAT_OVF_BIT   = 2;
  localparam int STAT_UNF_BIT   = 3;
endpackage

// File: rtl/sync_fifo_mem.sv
// sync_fifo_mem: stereo-pair register array, 1 write port, 1 registered read port
//   clk, rst_n          clock, async active-low reset (read register only; array is not reset)
//   we, waddr, wdata    write strobe, address, {left,right} pair
//   re, raddr           read strobe and address; rdata updates on the edge after re, else holds
module sync_fifo_mem import sync_sample_fifo_pkg::*; #(
  parameter int DATA_W     = DATA_W_DEF,
  parameter int DEPTH_LOG2 = DEPTH_LOG2_DEF
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    we,
  input  logic [DEPTH_LOG2-1:0]   waddr,
  input  logic [2*DATA_W-1:0]     wdata,
  input  logic                    re,
  input  logic [DEPTH_LOG2-1:0]   raddr,
  output logic [2*DATA_W-1:0]     rdata
);
  logic [2*DATA_W-1:0] mem [2**DEPTH_LOG2];
  always_ff @(posedge clk)
    if (we) mem[waddr] <= wdata;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) rdata <= '0;
    else if (re) rdata <= mem[raddr];
endmodule

// File: rtl/sync_sample_fifo.sv
// sync_sample_fifo: stereo sample FIFO between the audio receive port and the DSP datapath
//   clk, rst_n                                   clock, async active-low reset
//   write_en, iis_adsp_left/right_data           pair capture strobe and data
//   rd_en -> rd_left/right_data, rd_valid        read request, data/valid one cycle later
//   fifo_level, fifo_empty, fifo_full            registered occupancy status
//   regmap_fifo_flush, regmap_flag_clr           flush (highest priority), sticky flag clear
//   overflow_flg, underflow_flg                  sticky dropped-write / empty-read flags
//   IFIFO_UNDERFLOW_REPEAT_EN: empty reads still pulse rd_valid, re-presenting the last pair
module sync_sample_fifo import sync_sample_fifo_pkg::*; #(
  parameter int DATA_W     = DATA_W_DEF,
  parameter int DEPTH_LOG2 = DEPTH_LOG2_DEF
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  write_en,
  input  logic [DATA_W-1:0]     iis_adsp_left_data,
  input  logic [DATA_W-1:0]     iis_adsp_right_data,
  input  logic                  rd_en,
  output logic [DATA_W-1:0]     rd_left_data,
  output logic [DATA_W-1:0]     rd_right_data,
  output logic                  rd_valid,
  output logic [DEPTH_LOG2:0]   fifo_level,
  output logic                  fifo_empty,
  output logic                  fifo_full,
  input  logic                  regmap_fifo_flush,
  input  logic                  regmap_flag_clr,
  output logic                  overflow_flg,
  output logic                  underflow_flg
);
  localparam logic [DEPTH_LOG2:0] DEPTH = (DEPTH_LOG2+1)'(1) << DEPTH_LOG2;
  logic [DEPTH_LOG2-1:0] wr_ptr, rd_ptr;
  logic [DEPTH_LOG2:0]   lvl_nxt;
  logic [2*DATA_W-1:0]   rd_pair;
  logic wr_ok, rd_ok, ovf_set, unf_set, rd_show;
  // A write into a full FIFO is accepted when a read frees the slot on the same edge
  always_comb begin
    wr_ok   = write_en && !regmap_fifo_flush && (!fifo_full || rd_en);
    rd_ok   = rd_en && !regmap_fifo_flush && !fifo_empty;
    ovf_set = write_en && !regmap_fifo_flush && fifo_full && !rd_en;
    unf_set = rd_en && !regmap_fifo_flush && fifo_empty;
    lvl_nxt = regmap_fifo_flush ? '0 : fifo_level + (DEPTH_LOG2+1)'(wr_ok) - (DEPTH_LOG2+1)'(rd_ok);
  end
`ifdef IFIFO_UNDERFLOW_REPEAT_EN
  assign rd_show = rd_en && !regmap_fifo_flush;
`else
  assign rd_show = rd_ok;
`endif
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      fifo_level    <= '0;
      fifo_empty    <= 1'b1;
      fifo_full     <= 1'b0;
      rd_valid      <= 1'b0;
      overflow_flg  <= 1'b0;
      underflow_flg <= 1'b0;
    end else begin
      wr_ptr        <= regmap_fifo_flush ? '0 : wr_ptr + DEPTH_LOG2'(wr_ok);
      rd_ptr        <= regmap_fifo_flush ? '0 : rd_ptr + DEPTH_LOG2'(rd_ok);
      fifo_level    <= lvl_nxt;
      fifo_empty    <= lvl_nxt == '0;
      fifo_full     <= lvl_nxt == DEPTH;
      rd_valid      <= rd_show;
      overflow_flg  <= ovf_set || (overflow_flg && !regmap_flag_clr);
      underflow_flg <= unf_set || (underflow_flg && !regmap_flag_clr);
    end
  sync_fifo_mem #(.DATA_W(DATA_W), .DEPTH_LOG2(DEPTH_LOG2)) u_mem (
    .clk(clk),
    .rst_n(rst_n),
    .we(wr_ok),
    .waddr(wr_ptr),
    .wdata({iis_adsp_left_data, iis_adsp_right_data}),
    .re(rd_ok),
    .raddr(rd_ptr),
    .rdata(rd_pair)
  );
  assign rd_left_data  = rd_pair[2*DATA_W-1:DATA_W];
  assign rd_right_data = rd_pair[DATA_W-1:0];
endmodule
